// File: rtl/rbi_mmu_acl_fill_ctl.sv
// rbi_mmu_acl_fill_ctl: 4-entry ACL cache beside the ringbus MMU access checker.
// Takes software ACL loads, bulk invalidates and miss fills fetched over a req/ack port.
// Optional feature macro RBI_MMU_ACL_LRU_EN: LRU victim selection instead of round-robin.
module rbi_mmu_acl_fill_ctl #(
    parameter int TMO_CYC  = 255,
    parameter int TMO_BITS = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        regInHold,
    input  logic        invalAll,
    input  logic        ldaclValid,
    input  logic [47:0] ldaclData,
    input  logic        missReq,
    input  logic [31:0] missTag,
    output logic        fillReq,
    output logic [31:0] fillTag,
    input  logic        fillAck,
    input  logic        fillNone,
    input  logic [47:0] fillData,
    input  logic [3:0]  aclHitVec,
    output logic [47:0] aclEntryA,
    output logic [47:0] aclEntryB,
    output logic [47:0] aclEntryC,
    output logic [47:0] aclEntryD,
    output logic        missBusy,
    output logic        missDone,
    output logic        missFault
);

    typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_t;

    localparam logic [TMO_BITS-1:0] TMO_LAST = TMO_BITS'(TMO_CYC - 1);

    state_t              state, stateNext;
    logic [3:0][47:0]    ent;
    logic [TMO_BITS-1:0] count;
    logic [47:0]         fbuf;
    logic                stale, faultReg;
    logic [1:0]          victimSel;

    // Per-slot tag match; an entry is valid when its low access bits are non-zero
    function automatic logic [3:0] matchVec(input logic [3:0][47:0] e, input logic [31:0] t);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = (e[i][34:32] != 3'd0) && (e[i][31:0] == t);
        return m;
    endfunction

    // Lowest set bit as an index (slots hold unique tags, so at most one bit is set)
    function automatic logic [1:0] enc(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) if (v[i]) idx = 2'(i);
        return idx;
    endfunction

    logic        missHit, fillWr, wrEn;
    logic [31:0] wrTag;
    logic [47:0] wrData;
    logic [3:0]  wrMatch;
    logic [1:0]  wrIdx;

    assign missHit = |matchVec(ent, missTag);
    // Software loads own the single write port; a pending fill write waits behind them
    assign fillWr  = (state == WRITE) && !ldaclValid && !stale && !invalAll;
    assign wrEn    = ldaclValid || fillWr;
    assign wrTag   = ldaclValid ? ldaclData[31:0] : fillTag;
    assign wrData  = ldaclValid ? ldaclData : fbuf;
    assign wrMatch = matchVec(ent, wrTag);
    assign wrIdx   = (|wrMatch) ? enc(wrMatch) : victimSel;

    assign fillReq   = (state == REQ);
    assign missBusy  = (state == REQ) || (state == WRITE);
    assign missDone  = (state == DONE);
    assign missFault = (state == DONE) && faultReg;

    assign aclEntryA = ent[0];
    assign aclEntryB = ent[1];
    assign aclEntryC = ent[2];
    assign aclEntryD = ent[3];

    // Next-state logic for the miss/fill sequencer
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:  if (missReq && !regInHold) stateNext = missHit ? DONE : REQ;
            REQ: begin
                if (fillAck) stateNext = (fillNone || stale || invalAll) ? DONE : WRITE;
                else if (count == TMO_LAST) stateNext = DONE;
            end
            WRITE: if (!ldaclValid) stateNext = DONE;
            DONE:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Sequencer state, timeout counter, latched tag, fill buffer and stale/fault flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            fillTag  <= '0;
            fbuf     <= '0;
            stale    <= 1'b0;
            faultReg <= 1'b0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: if (missReq && !regInHold) begin
                    fillTag  <= missTag;
                    count    <= '0;
                    stale    <= 1'b0;
                    faultReg <= 1'b0;
                end
                REQ: begin
                    count <= count + 1'b1;
                    if (invalAll) stale <= 1'b1;
                    if (fillAck) fbuf <= fillData;
                    else if (count == TMO_LAST) faultReg <= 1'b1;
                end
                WRITE: if (invalAll) stale <= 1'b1;
                default: ;
            endcase
        end
    end

    // Entry array: invalidate-all beats any same-cycle write
    always_ff @(posedge clock or posedge reset) begin
        if (reset) ent <= '0;
        else if (invalAll) ent <= '0;
        else if (wrEn) ent[wrIdx] <= wrData;
    end

`ifdef RBI_MMU_ACL_LRU_EN
    // Age per slot: 0 = most recent, 3 = least recent; ages always form a permutation
    logic [3:0][1:0] age;
    logic            hitOneHot, touchEn;
    logic [1:0]      touchIdx;

    assign hitOneHot = (aclHitVec != 4'd0) && ((aclHitVec & (aclHitVec - 4'd1)) == 4'd0);
    assign touchEn   = wrEn || hitOneHot;
    assign touchIdx  = wrEn ? wrIdx : enc(aclHitVec);

    // Victim: lowest-index invalid slot, otherwise the oldest slot
    always_comb begin
        victimSel = 2'd0;
        for (int i = 3; i >= 0; i--) if (age[i] == 2'd3) victimSel = 2'(i);
        for (int i = 3; i >= 0; i--) if (ent[i][34:32] == 3'd0) victimSel = 2'(i);
    end

    // Age update: touched slot becomes newest, younger slots age by one
    always_ff @(posedge clock or posedge reset) begin
        if (reset) age <= {2'd0, 2'd1, 2'd2, 2'd3};
        else if (invalAll) age <= {2'd0, 2'd1, 2'd2, 2'd3};
        else if (touchEn) begin
            for (int j = 0; j < 4; j++) begin
                if (2'(j) == touchIdx) age[j] <= 2'd0;
                else if (age[j] < age[touchIdx]) age[j] <= age[j] + 2'd1;
            end
        end
    end
`else
    logic [1:0] victim;
    logic       unusedHit;

    assign unusedHit = ^aclHitVec;
    assign victimSel = victim;

    // Round-robin pointer advances only when a write lands on the victim slot
    always_ff @(posedge clock or posedge reset) begin
        if (reset) victim <= 2'd0;
        else if (invalAll) victim <= 2'd0;
        else if (wrEn && !(|wrMatch)) victim <= victim + 2'd1;
    end
`endif

endmodule

// File: tb/tb_rbi_mmu_acl_fill_ctl.sv
// Directed self-checking bench for rbi_mmu_acl_fill_ctl (timeout shortened to 8 cycles).
module tb_rbi_mmu_acl_fill_ctl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        regInHold = 1'b0, invalAll = 1'b0, ldaclValid = 1'b0;
    logic [47:0] ldaclData = '0;
    logic        missReq = 1'b0;
    logic [31:0] missTag = '0;
    logic        fillReq;
    logic [31:0] fillTag;
    logic        fillAck = 1'b0, fillNone = 1'b0;
    logic [47:0] fillData = '0;
    logic [3:0]  aclHitVec = '0;
    logic [47:0] aclEntryA, aclEntryB, aclEntryC, aclEntryD;
    logic        missBusy, missDone, missFault;

    int checks = 0;
    int errors = 0;

    rbi_mmu_acl_fill_ctl #(.TMO_CYC(8), .TMO_BITS(8)) dut (
        .clock(clock), .reset(reset), .regInHold(regInHold), .invalAll(invalAll),
        .ldaclValid(ldaclValid), .ldaclData(ldaclData), .missReq(missReq), .missTag(missTag),
        .fillReq(fillReq), .fillTag(fillTag), .fillAck(fillAck), .fillNone(fillNone),
        .fillData(fillData), .aclHitVec(aclHitVec),
        .aclEntryA(aclEntryA), .aclEntryB(aclEntryB), .aclEntryC(aclEntryC), .aclEntryD(aclEntryD),
        .missBusy(missBusy), .missDone(missDone), .missFault(missFault)
    );

    always #5 clock = ~clock;

    function automatic logic [47:0] E(input logic [11:0] acc, input logic [31:0] tag);
        return {4'h0, acc, tag};
    endfunction

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic ldacl(input logic [47:0] d);
        ldaclValid = 1'b1;
        ldaclData  = d;
        step();
        ldaclValid = 1'b0;
    endtask

    initial begin
        int n;
        // Reset state
        #2;
        check("rst_A", aclEntryA, 48'h0);
        check("rst_D", aclEntryD, 48'h0);
        check("rst_fillReq", {47'h0, fillReq}, 48'h0);
        check("rst_busy_done_fault", {45'h0, missBusy, missDone, missFault}, 48'h0);
        check("rst_fillTag", {16'h0, fillTag}, 48'h0);
        step();
        reset = 1'b0;
        step();

        // 1: five loads wrap the victim pointer
        for (int i = 1; i <= 5; i++) ldacl(E(12'h007, 32'(i)));
        check("t1_A", aclEntryA, E(12'h007, 32'd5));
        check("t1_B", aclEntryB, E(12'h007, 32'd2));
        check("t1_C", aclEntryC, E(12'h007, 32'd3));
        check("t1_D", aclEntryD, E(12'h007, 32'd4));

        // 2: normal fill, ack in third request cycle, lands in slot B
        missReq = 1'b1; missTag = 32'h0042_0010;
        step();
        check("t2_req_c1", {47'h0, fillReq}, 48'h1);
        check("t2_busy", {47'h0, missBusy}, 48'h1);
        check("t2_fillTag", {16'h0, fillTag}, {16'h0, 32'h0042_0010});
        step();
        check("t2_req_c2", {47'h0, fillReq}, 48'h1);
        step();
        check("t2_req_c3", {47'h0, fillReq}, 48'h1);
        fillAck = 1'b1; fillData = E(12'h001, 32'h0042_0010);
        step();
        fillAck = 1'b0;
        check("t2_write_req", {47'h0, fillReq}, 48'h0);
        check("t2_write_done", {47'h0, missDone}, 48'h0);
        step();
        check("t2_done", {46'h0, missDone, missFault}, 48'h2);
        check("t2_B", aclEntryB, E(12'h001, 32'h0042_0010));
        check("t2_A", aclEntryA, E(12'h007, 32'd5));
        missReq = 1'b0;
        step();
        check("t2_done_pulse", {47'h0, missDone}, 48'h0);

        // 3: timeout after 8 request cycles, no write, late ack ignored
        missReq = 1'b1; missTag = 32'h0099_0001;
        step();
        n = 0;
        for (int i = 0; i < 20 && fillReq; i++) begin n++; step(); end
        check("t3_req_cycles", 48'(n), 48'd8);
        check("t3_done_fault", {46'h0, missDone, missFault}, 48'h3);
        check("t3_C", aclEntryC, E(12'h007, 32'd3));
        missReq = 1'b0; fillAck = 1'b1; fillData = E(12'h005, 32'h0099_0001);
        step();
        fillAck = 1'b0;
        check("t3_late_ack_C", aclEntryC, E(12'h007, 32'd3));
        check("t3_late_ack_fault", {45'h0, fillReq, missDone, missFault}, 48'h0);
        step();
        check("t3_late_ack_D", aclEntryD, E(12'h007, 32'd4));

        // 4: invalidate during request makes the fill stale
        missReq = 1'b1; missTag = 32'h0077_0002;
        step();
        invalAll = 1'b1;
        step();
        invalAll = 1'b0;
        check("t4_inval_A", aclEntryA, 48'h0);
        check("t4_inval_B", aclEntryB, 48'h0);
        check("t4_still_req", {47'h0, fillReq}, 48'h1);
        fillAck = 1'b1; fillData = E(12'h003, 32'h0077_0002);
        step();
        fillAck = 1'b0;
        check("t4_done", {46'h0, missDone, missFault}, 48'h2);
        check("t4_no_write", aclEntryA | aclEntryB | aclEntryC | aclEntryD, 48'h0);
        missReq = 1'b0;
        step();

        // 5a: ldacl during WRITE defers the fill write by a cycle
        missReq = 1'b1; missTag = 32'h0000_0100;
        step();
        fillAck = 1'b1; fillData = E(12'h003, 32'h0000_0100);
        step();
        fillAck = 1'b0;
        ldacl(E(12'h005, 32'h0000_0200));
        check("t5_ld_A", aclEntryA, E(12'h005, 32'h0000_0200));
        check("t5_wait_busy", {46'h0, missBusy, missDone}, 48'h2);
        step();
        check("t5_fill_B", aclEntryB, E(12'h003, 32'h0000_0100));
        check("t5_done", {47'h0, missDone}, 48'h1);
        missReq = 1'b0;
        step();

        // 5b: fill tag becomes resident mid-fill, overwrite matching slot
        missReq = 1'b1; missTag = 32'h0000_0300;
        step();
        ldacl(E(12'h006, 32'h0000_0300));
        check("t5_ld_C", aclEntryC, E(12'h006, 32'h0000_0300));
        fillAck = 1'b1; fillData = E(12'h002, 32'h0000_0300);
        step();
        fillAck = 1'b0;
        step();
        check("t5_merge_C", aclEntryC, E(12'h002, 32'h0000_0300));
        check("t5_merge_D", aclEntryD, 48'h0);
        missReq = 1'b0;
        step();
        ldacl(E(12'h007, 32'h0000_0400));
        check("t5_victim_D", aclEntryD, E(12'h007, 32'h0000_0400));

        // Resident miss completes without fetch
        missReq = 1'b1; missTag = 32'h0000_0200;
        step();
        check("res_done", {45'h0, fillReq, missDone, missFault}, 48'h2);
        missReq = 1'b0;
        step();

        // Hold blocks miss acceptance
        regInHold = 1'b1; missReq = 1'b1; missTag = 32'h0000_0600;
        step();
        step();
        check("hold_idle", {46'h0, fillReq, missBusy}, 48'h0);
        missReq = 1'b0; regInHold = 1'b0;

        // Loading an invalid entry onto a matching slot invalidates it
        ldacl(E(12'h000, 32'h0000_0400));
        check("inv_ld_D", aclEntryD, E(12'h000, 32'h0000_0400));
        check("inv_ld_C", aclEntryC, E(12'h002, 32'h0000_0300));

        // Reset mid-fill drops fillReq at once; late ack ignored
        missReq = 1'b1; missTag = 32'h0000_0500;
        step();
        check("mid_req", {47'h0, fillReq}, 48'h1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_req", {46'h0, fillReq, missBusy}, 48'h0);
        check("mid_rst_A", aclEntryA, 48'h0);
        missReq = 1'b0;
        step();
        reset = 1'b0;
        fillAck = 1'b1; fillData = E(12'h007, 32'h0000_0500);
        step();
        fillAck = 1'b0;
        check("mid_late_ack", {45'h0, fillReq, missDone, missBusy}, 48'h0);
        check("mid_late_A", aclEntryA, 48'h0);

`ifdef RBI_MMU_ACL_LRU_EN
        // LRU: fill A-D, hit A,B,C, new load replaces D
        for (int i = 1; i <= 4; i++) ldacl(E(12'h007, 32'(i)));
        aclHitVec = 4'b0001; step();
        aclHitVec = 4'b0010; step();
        aclHitVec = 4'b0100; step();
        aclHitVec = 4'b0000;
        ldacl(E(12'h007, 32'd9));
        check("lru_D", aclEntryD, E(12'h007, 32'd9));
        check("lru_A", aclEntryA, E(12'h007, 32'd1));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
